// File: rtl/aes_encipher_block.sv
// ---------------------------------------------------------------------------
// aes_encipher_block
//
// Iterative AES encipher datapath. One block is encrypted per `next` pulse
// using an external round-key store and an external (shared) 32-bit S-box.
// SubBytes is done one 32-bit word per cycle through the shared S-box,
// followed by a single ShiftRows/MixColumns/AddRoundKey cycle per round.
//
// Ports:
//   clk        in   1    clock, rising edge
//   reset_n    in   1    asynchronous active-low reset
//   next       in   1    start one block encryption (sampled in IDLE only)
//   keylen     in   1    0 = AES-128 (10 rounds), 1 = AES-256 (14 rounds)
//   key_ready  in   1    round-key store ready flag
//   round      out  4    round-key index requested from the key store
//   round_key  in   128  key for `round` (combinational return)
//   sboxw      out  32   word presented to the shared S-box
//   new_sboxw  in   32   S-box result for sboxw (combinational return)
//   block      in   128  plaintext
//   new_block  out  128  state register; ciphertext when ready = 1
//   ready      out  1    idle / done
//
// Configuration macro:
//   AES_ENC_KEY_READY_GATE_EN  when defined, `next` is accepted only while
//                              key_ready = 1; otherwise key_ready is unused.
// ---------------------------------------------------------------------------
module aes_encipher_block (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         next,
    input  logic         keylen,
    input  logic         key_ready,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    output logic [31:0]  sboxw,
    input  logic [31:0]  new_sboxw,
    input  logic [127:0] block,
    output logic [127:0] new_block,
    output logic         ready
);

    typedef enum logic [1:0] {
        CTRL_IDLE,
        CTRL_INIT,
        CTRL_SBOX,
        CTRL_MAIN
    } ctrl_state_t;

    // -----------------------------------------------------------------------
    // GF(2^8) helpers (polynomial 0x11b)
    // -----------------------------------------------------------------------
    function automatic logic [7:0] gm2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm3(input logic [7:0] b);
        return gm2(b) ^ b;
    endfunction

    function automatic logic [31:0] mixw(input logic [31:0] w);
        logic [7:0] b0, b1, b2, b3;
        b0 = w[31:24];
        b1 = w[23:16];
        b2 = w[15:8];
        b3 = w[7:0];
        return {gm2(b0) ^ gm3(b1) ^ b2      ^ b3,
                b0      ^ gm2(b1) ^ gm3(b2) ^ b3,
                b0      ^ b1      ^ gm2(b2) ^ gm3(b3),
                gm3(b0) ^ b1      ^ b2      ^ gm2(b3)};
    endfunction

    // Column c = word c (word 0 = bits 127:96); row r of a column is byte r
    // of that word counting from the MSB.
    function automatic logic [127:0] mixcolumns(input logic [127:0] d);
        return {mixw(d[127:96]), mixw(d[95:64]), mixw(d[63:32]), mixw(d[31:0])};
    endfunction

    function automatic logic [127:0] shiftrows(input logic [127:0] d);
        logic [31:0] w0, w1, w2, w3;
        w0 = d[127:96];
        w1 = d[95:64];
        w2 = d[63:32];
        w3 = d[31:0];
        return {w0[31:24], w1[23:16], w2[15:8], w3[7:0],
                w1[31:24], w2[23:16], w3[15:8], w0[7:0],
                w2[31:24], w3[23:16], w0[15:8], w1[7:0],
                w3[31:24], w0[23:16], w1[15:8], w2[7:0]};
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    ctrl_state_t  state_reg, state_new;
    logic [127:0] block_reg, block_new;
    logic [3:0]   round_ctr, round_ctr_new;
    logic [1:0]   sword_ctr, sword_ctr_new;
    logic         ready_reg, ready_new;
    logic         keylen_reg, keylen_new;
    logic         start;
    logic [3:0]   num_rounds;

`ifdef AES_ENC_KEY_READY_GATE_EN
    assign start = next & key_ready;
`else
    logic unused_key_ready;
    assign unused_key_ready = key_ready;
    assign start = next;
`endif

    // Key length is captured at acceptance so a change on the port while
    // busy cannot alter the round count of the block in flight.
    assign num_rounds = keylen_reg ? 4'd14 : 4'd10;

    assign round     = round_ctr;
    assign new_block = block_reg;
    assign ready     = ready_reg;

    always_comb begin
        sboxw = '0;
        case (sword_ctr)
            2'd0: sboxw = block_reg[127:96];
            2'd1: sboxw = block_reg[95:64];
            2'd2: sboxw = block_reg[63:32];
            2'd3: sboxw = block_reg[31:0];
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= CTRL_IDLE;
            block_reg  <= '0;
            round_ctr  <= '0;
            sword_ctr  <= '0;
            ready_reg  <= 1'b1;
            keylen_reg <= 1'b0;
        end else begin
            state_reg  <= state_new;
            block_reg  <= block_new;
            round_ctr  <= round_ctr_new;
            sword_ctr  <= sword_ctr_new;
            ready_reg  <= ready_new;
            keylen_reg <= keylen_new;
        end
    end

    always_comb begin
        state_new     = state_reg;
        block_new     = block_reg;
        round_ctr_new = round_ctr;
        sword_ctr_new = sword_ctr;
        ready_new     = ready_reg;
        keylen_new    = keylen_reg;

        case (state_reg)
            CTRL_IDLE: begin
                if (start) begin
                    ready_new     = 1'b0;
                    round_ctr_new = '0;
                    keylen_new    = keylen;
                    state_new     = CTRL_INIT;
                end
            end

            CTRL_INIT: begin
                block_new     = block ^ round_key;
                round_ctr_new = 4'd1;
                sword_ctr_new = '0;
                state_new     = CTRL_SBOX;
            end

            CTRL_SBOX: begin
                case (sword_ctr)
                    2'd0: block_new[127:96] = new_sboxw;
                    2'd1: block_new[95:64]  = new_sboxw;
                    2'd2: block_new[63:32]  = new_sboxw;
                    2'd3: block_new[31:0]   = new_sboxw;
                endcase
                sword_ctr_new = sword_ctr + 2'd1;
                if (sword_ctr == 2'd3)
                    state_new = CTRL_MAIN;
            end

            CTRL_MAIN: begin
                if (round_ctr < num_rounds) begin
                    block_new     = mixcolumns(shiftrows(block_reg)) ^ round_key;
                    round_ctr_new = round_ctr + 4'd1;
                    sword_ctr_new = '0;
                    state_new     = CTRL_SBOX;
                end else begin
                    // Final round: no MixColumns.
                    block_new = shiftrows(block_reg) ^ round_key;
                    ready_new = 1'b1;
                    state_new = CTRL_IDLE;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_aes_encipher_block.sv
module tb_aes_encipher_block;

    logic         clk;
    logic         reset_n;
    logic         next;
    logic         keylen;
    logic         key_ready;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic [31:0]  sboxw;
    logic [31:0]  new_sboxw;
    logic [127:0] block;
    logic [127:0] new_block;
    logic         ready;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]   sbox [256];
    logic [127:0] rk   [15];
    logic [127:0] st   [15];

    aes_encipher_block dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .next      (next),
        .keylen    (keylen),
        .key_ready (key_ready),
        .round     (round),
        .round_key (round_key),
        .sboxw     (sboxw),
        .new_sboxw (new_sboxw),
        .block     (block),
        .new_block (new_block),
        .ready     (ready)
    );

    // Attached round-key store and S-box.
    assign round_key = rk[round];
    assign new_sboxw = {sbox[sboxw[31:24]], sbox[sboxw[23:16]],
                        sbox[sboxw[15:8]],  sbox[sboxw[7:0]]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Reference model: textbook AES on byte arrays
    // ------------------------------------------------------------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                      ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    task automatic expand_key(input logic [255:0] key, input bit kl);
        logic [31:0] w [60];
        logic [31:0] temp;
        logic [7:0]  rc;
        int nk, nr;
        nk = kl ? 8 : 4;
        nr = kl ? 14 : 10;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            temp = w[i-1];
            if (i % nk == 0) begin
                temp = subword({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk == 8 && i % nk == 4) begin
                temp = subword(temp);
            end
            w[i] = w[i-nk] ^ temp;
        end
        for (int r = 0; r < 15; r++)
            rk[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
    endtask

    // Fills st[0] (after initial AddRoundKey) .. st[nr] (ciphertext).
    task automatic ref_encrypt(input logic [127:0] pt, input int nr);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [127:0] v;
        v = pt ^ rk[0];
        st[0] = v;
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox[v[127 - 8*i -: 8]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[4*c + row] = s[4*((c + row) % 4) + row];
            if (r < nr) begin
                for (int c = 0; c < 4; c++) begin
                    s[4*c+0] = gmul(t[4*c],2) ^ gmul(t[4*c+1],3) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1],2) ^ gmul(t[4*c+2],3) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2],2) ^ gmul(t[4*c+3],3);
                    s[4*c+3] = gmul(t[4*c],3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3],2);
                end
            end else begin
                for (int i = 0; i < 16; i++) s[i] = t[i];
            end
            for (int i = 0; i < 16; i++) v[127 - 8*i -: 8] = s[i];
            v = v ^ rk[r];
            st[r] = v;
        end
    endtask

    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One encryption with full monitoring. glitch_at / reset_at: edge count
    // at which to re-pulse next or assert reset (0 = never).
    task automatic do_run(input string tag, input logic [127:0] pt, input logic [255:0] key,
                          input bit kl, input bit kr, input int glitch_at, input int reset_at,
                          output logic [127:0] result);
        logic [3:0]  smp_round [80];
        logic [31:0] smp_sboxw [80];
        int nr, edges, ns, er, ph, mr, ms;
        nr = kl ? 14 : 10;
        expand_key(key, kl);
        ref_encrypt(pt, nr);
        result = new_block;

        @(negedge clk);
        block = pt; keylen = kl; key_ready = kr; next = 1'b1;
        @(negedge clk);
        next = 1'b0;
        edges = 1;
        ns = 0;
        while (ready !== 1'b1 && edges < 5*nr + 20) begin
            if (ns < 80) begin
                smp_round[ns] = round;
                smp_sboxw[ns] = sboxw;
                ns++;
            end
            if (edges == reset_at) begin
                reset_n = 1'b0;
                #1;
                check({tag, "_rst_ready"}, 128'(ready), 128'(1));
                check({tag, "_rst_block"}, new_block, '0);
                check({tag, "_rst_round"}, 128'(round), 128'(0));
                @(negedge clk);
                reset_n = 1'b1;
                result = new_block;
                return;
            end
            next = (edges == glitch_at);
            if (edges == glitch_at) block = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            edges++;
        end
        next = 1'b0;
        result = new_block;

        check({tag, "_latency"}, 128'(edges - 1), 128'(5*nr + 1));
        check({tag, "_ready"}, 128'(ready), 128'(1));
        check({tag, "_cipher"}, new_block, st[nr]);

        mr = 0;
        ms = 0;
        for (int s = 0; s < ns; s++) begin
            er = (s == 0) ? 0 : (s - 1) / 5 + 1;
            if (smp_round[s] !== 4'(er)) mr++;
            if (s > 0) begin
                ph = (s - 1) % 5;
                if (ph < 4 && smp_sboxw[s] !== st[er-1][127 - 32*ph -: 32]) ms++;
            end
        end
        check({tag, "_round_seq_errs"}, 128'(mr), 128'(0));
        check({tag, "_sboxw_seq_errs"}, 128'(ms), 128'(0));
    endtask

    // ------------------------------------------------------------------
    localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY256 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

    initial begin
        logic [127:0] res;
        logic [255:0] rkey;
        logic [127:0] rpt;
        bit           rkl;

        reset_n = 1'b0;
        next = 1'b0; keylen = 1'b0; key_ready = 1'b0; block = '0;
        for (int r = 0; r < 15; r++) rk[r] = '0;
        build_sbox();

        @(negedge clk);
        check("reset_ready", 128'(ready), 128'(1));
        check("reset_block", new_block, '0);
        check("reset_round", 128'(round), 128'(0));
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_ready", 128'(ready), 128'(1));
        check("idle_block", new_block, '0);

`ifdef AES_ENC_KEY_READY_GATE_EN
        expand_key(KEY128, 1'b0);
        block = PT; keylen = 1'b0; key_ready = 1'b0; next = 1'b1;
        @(negedge clk);
        next = 1'b0;
        check("gate_ready", 128'(ready), 128'(1));
        check("gate_round", 128'(round), 128'(0));
        @(negedge clk);
        check("gate_ready2", 128'(ready), 128'(1));
        do_run("kat128", PT, KEY128, 1'b0, 1'b1, 0, 0, res);
`else
        // key_ready is ignored in this build: run with it low.
        do_run("kat128", PT, KEY128, 1'b0, 1'b0, 0, 0, res);
`endif
        check("kat128_const", res, CT128);

        repeat (6) @(negedge clk);
        check("hold_block", new_block, CT128);
        check("hold_ready", 128'(ready), 128'(1));

        do_run("kat256", PT, KEY256, 1'b1, 1'b1, 0, 0, res);
        check("kat256_const", res, CT256);

        do_run("repulse", PT, KEY128, 1'b0, 1'b1, 10, 0, res);
        check("repulse_const", res, CT128);

        do_run("midreset", PT, KEY256, 1'b1, 1'b1, 0, 20, res);
        check("after_rst_ready", 128'(ready), 128'(1));
        check("after_rst_block", new_block, '0);
        do_run("post_rst", PT, KEY128, 1'b0, 1'b1, 0, 0, res);
        check("post_rst_const", res, CT128);

        for (int k = 0; k < 6; k++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom,
                    $urandom, $urandom, $urandom, $urandom};
            rpt  = {$urandom, $urandom, $urandom, $urandom};
            rkl  = bit'($urandom_range(0, 1));
            if (!rkl) rkey[127:0] = '0;
            do_run($sformatf("rand%0d", k), rpt, rkey, rkl, 1'b1, 0, 0, res);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_encipher_block.md
AES_ENCIPHER_BLOCK -- requirements
Module: aes_encipher_block

Interface
REQ-001 SHALL have ports: clk  in  1  clock, rising edge; reset_n  in  1  reset, asynchronous, active-low.
REQ-002 SHALL have port: next  in  1  start one block encryption; sampled only in IDLE.
REQ-003 SHALL have port: keylen  in  1  0 = AES-128 (10 rounds), 1 = AES-256 (14 rounds); held stable while busy.
REQ-004 SHALL have port: key_ready  in  1  round-key store ready flag.
REQ-005 SHALL have port: round  out  4  round-key index requested from the round-key store.
REQ-006 SHALL have port: round_key  in  128  key for `round`, combinational return, same cycle.
REQ-007 SHALL have port: sboxw  out  32  word presented to the shared S-box.
REQ-008 SHALL have port: new_sboxw  in  32  S-box result for sboxw, combinational, same cycle.
REQ-009 SHALL have ports: block  in  128  plaintext; new_block  out  128  state register, valid ciphertext when ready=1; ready  out  1  idle/done.

Function
REQ-010 SHALL implement FSM IDLE, INIT, SBOX, MAIN; 128-bit block_reg, 4-bit round_ctr, 2-bit sword_ctr.
REQ-011 IDLE: next=1 -> ready<=0, round_ctr<=0, go INIT; otherwise hold, block_reg unchanged.
REQ-012 INIT: block_reg <= block ^ round_key (round=0); round_ctr<=1; sword_ctr<=0; go SBOX.
REQ-013 SBOX: sboxw = block_reg word sword_ctr (word 0 = bits 127:96); that word <= new_sboxw; sword_ctr++; after word 3 go MAIN.
REQ-014 MAIN, round_ctr < num_rounds: block_reg <= MixColumns(ShiftRows(block_reg)) ^ round_key; round_ctr++; sword_ctr<=0; go SBOX.
REQ-015 MAIN, round_ctr == num_rounds: block_reg <= ShiftRows(block_reg) ^ round_key; ready<=1; go IDLE.
REQ-016 round output SHALL equal round_ctr_reg in all states (0 in INIT).
REQ-017 sboxw SHALL be block_reg word sword_ctr when not in SBOX (don't-care content, but deterministic).
REQ-018 Latency: ready rises 51 edges (AES-128) / 71 edges (AES-256) after the edge sampling next.
REQ-019 next while busy (ready=0) SHALL be ignored; block and keylen not resampled.
REQ-020 new_block SHALL be block_reg continuously; after completion it holds until next accepted encryption's INIT.
REQ-021 GF(2^8) xtime SHALL use polynomial 0x11b; MixColumns per FIPS-197 column order, column 0 = bits 127:96.

Reset
REQ-022 reset_n low SHALL asynchronously set state=IDLE, ready=1, block_reg=0 (new_block=0), round_ctr=0, sword_ctr=0.
REQ-023 Reset mid-encryption SHALL abort; after release block in IDLE, ready=1, new_block=0, next accepted on first edge.

Configuration
REQ-024 Macro AES_ENC_KEY_READY_GATE_EN defined: next in IDLE SHALL be accepted only when key_ready=1; next with key_ready=0 ignored, ready stays 1.
REQ-025 Macro undefined: key_ready SHALL be ignored (port present, unused); next accepted regardless.

Verification
REQ-026 Key mem + S-box attached, AES-128 key 000102030405060708090a0b0c0d0e0f, block 00112233445566778899aabbccddeeff, next pulse -> ready after 51 edges, new_block 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-027 AES-256 key 000102...1e1f, same block -> ready after 71 edges, new_block 8ea2b7ca516745bfeafc49904b496089.
REQ-028 next re-pulsed at cycle 10 with different block during AES-128 run -> ignored, result still 69c4e0d86a7b0430d8cdb78070b4c55a at edge 51.
REQ-029 reset_n low at cycle 20 of a run -> ready=1, new_block=0 immediately; new next after release yields correct ciphertext.
REQ-030 With AES_ENC_KEY_READY_GATE_EN, key_ready=0 and next=1 -> ready stays 1, round stays 0; key_ready=1 next=1 -> run starts, round=0 during INIT then 1.
REQ-031 Round monitor: round sequence 0,1(x5),2(x5)..10(x5) for AES-128; sboxw words in order 0..3 each round.
